// File: rtl/ps2_host_tx_fifo.sv
// ps2_host_tx_fifo: queued PS/2 host-to-device transmitter.
// Accepts command bytes into a small FIFO and sends each one as an 11-bit
// frame: inhibit, request-to-send, start, data LSB first, odd parity, stop.
// It then checks the device ACK. A watchdog bounds each frame from clock release.
// Optional macro PS2_TX_RETRY_EN: when defined, a failed byte is retried up to
// MAX_RETRY times before TX_ERROR is reported.
// Ports:
//   CLK, RESET_N                   clock, async active-low reset
//   CLK_PS2_IN, DATA_PS2_IN        raw PS/2 line levels (asynchronous)
//   CLK_PS2_OUT_EN                 1 = pull PS/2 clock low
//   DATA_PS2_OUT, DATA_PS2_OUT_EN  data line drive value / enable
//   SEND_BYTE, BYTE_TO_SEND        one-cycle push into the queue
//   FIFO_FULL, BUSY                queue full / block active
//   BYTE_SENT, TX_ERROR            one-cycle completion / abandon pulses
//   ERROR_CODE                     01 timeout, 10 NACK, held until next error
module ps2_host_tx_fifo #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned TIMEOUT_CYCLES = 2000000,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned MAX_RETRY      = 2
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       CLK_PS2_IN,
    output logic       CLK_PS2_OUT_EN,
    input  logic       DATA_PS2_IN,
    output logic       DATA_PS2_OUT,
    output logic       DATA_PS2_OUT_EN,
    input  logic       SEND_BYTE,
    input  logic [7:0] BYTE_TO_SEND,
    output logic       FIFO_FULL,
    output logic       BUSY,
    output logic       BYTE_SENT,
    output logic       TX_ERROR,
    output logic [1:0] ERROR_CODE
);

    localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned TMR_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
`ifdef PS2_TX_RETRY_EN
    localparam int unsigned RETRY_LIMIT = MAX_RETRY;
`else
    // Retries disabled: every failure is final.
    localparam int unsigned RETRY_LIMIT = MAX_RETRY * 0;
`endif
    localparam int unsigned RTY_W   = (RETRY_LIMIT > 0) ? $clog2(RETRY_LIMIT + 1) : 1;

    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_NACK    = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_REL
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
    logic               clk_prev_q, clk_prev_d;
    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [7:0]         mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [7:0]         byte_q, byte_d;
    logic [2:0]         idx_q, idx_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [RTY_W-1:0]   retry_q, retry_d;
    logic [1:0]         err_code_q, err_code_d;
    logic               clk_oe_q, clk_oe_d, data_oe_q, data_oe_d, data_out_q, data_out_d;
    logic               full_q, full_d, busy_q, busy_d, sent_q, sent_d, tx_err_q, tx_err_d;

    logic               clk_s, data_s, clk_fall, push, pop, fail, wd_active;
    logic [1:0]         fail_code;

    assign clk_s    = clk_sync_q[1];
    assign data_s   = data_sync_q[1];
    assign clk_fall = clk_prev_q & ~clk_s;
    assign push     = SEND_BYTE && (count_q != CNT_W'(FIFO_DEPTH));

    // Input synchronisers and falling-edge history.
    always_comb begin
        clk_sync_d  = {clk_sync_q[0], CLK_PS2_IN};
        data_sync_d = {data_sync_q[0], DATA_PS2_IN};
        clk_prev_d  = clk_s;
    end

    // Frame sequencing, watchdog, retry and error bookkeeping.
    always_comb begin
        state_d    = state_q;
        byte_d     = byte_q;
        idx_d      = idx_q;
        tmr_d      = tmr_q;
        retry_d    = retry_q;
        err_code_d = err_code_q;
        pop        = 1'b0;
        sent_d     = 1'b0;
        tx_err_d   = 1'b0;
        fail       = 1'b0;
        fail_code  = 2'b00;
        wd_active  = state_q inside {S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_REL};

        if (wd_active) begin
            tmr_d = tmr_q + TMR_W'(1);
        end

        if (wd_active && (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1))) begin
            fail      = 1'b1;
            fail_code = ERR_TIMEOUT;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (count_q != '0) begin
                        byte_d  = mem_q[rd_ptr_q];
                        idx_d   = 3'd0;
                        tmr_d   = '0;
                        state_d = S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (tmr_q == TMR_W'(INHIBIT_CYCLES - 1)) begin
                        tmr_d   = '0;
                        state_d = S_REQ;
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
                S_REQ: begin
                    tmr_d   = '0;
                    state_d = S_START;
                end
                S_START: begin
                    if (clk_fall) begin
                        idx_d   = 3'd0;
                        state_d = S_DATA;
                    end
                end
                S_DATA: begin
                    if (clk_fall) begin
                        if (idx_q == 3'd7) state_d = S_PARITY;
                        else               idx_d   = idx_q + 3'd1;
                    end
                end
                S_PARITY: begin
                    if (clk_fall) state_d = S_STOP;
                end
                S_STOP: begin
                    // Device ACK is a low data line at the eleventh falling edge.
                    if (clk_fall) begin
                        if (!data_s) begin
                            state_d = S_WAIT_REL;
                        end else begin
                            fail      = 1'b1;
                            fail_code = ERR_NACK;
                        end
                    end
                end
                S_WAIT_REL: begin
                    if (clk_s && data_s) begin
                        sent_d  = 1'b1;
                        pop     = 1'b1;
                        retry_d = '0;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Failed attempt: release the bus; IDLE restarts the same head byte unless it is final.
        if (fail) begin
            state_d = S_IDLE;
            tmr_d   = '0;
            if (retry_q == RTY_W'(RETRY_LIMIT)) begin
                tx_err_d   = 1'b1;
                err_code_d = fail_code;
                pop        = 1'b1;
                retry_d    = '0;
            end else begin
                retry_d = retry_q + RTY_W'(1);
            end
        end
    end

    // Command queue and registered outputs derived from next-state values.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = BYTE_TO_SEND;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (!push && pop) count_d = count_q - CNT_W'(1);

        clk_oe_d   = state_d inside {S_INHIBIT, S_REQ};
        data_oe_d  = state_d inside {S_REQ, S_START, S_DATA, S_PARITY};
        data_out_d = 1'b0;
        if (state_d == S_DATA)   data_out_d = byte_d[idx_d];
        if (state_d == S_PARITY) data_out_d = ~^byte_d;
        full_d     = (count_d == CNT_W'(FIFO_DEPTH));
        busy_d     = (state_d != S_IDLE) || (count_d != '0);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= S_IDLE;
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            clk_prev_q  <= 1'b1;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            byte_q      <= 8'h00;
            idx_q       <= 3'd0;
            tmr_q       <= '0;
            retry_q     <= '0;
            err_code_q  <= 2'b00;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            data_out_q  <= 1'b0;
            full_q      <= 1'b0;
            busy_q      <= 1'b0;
            sent_q      <= 1'b0;
            tx_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            clk_prev_q  <= clk_prev_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            byte_q      <= byte_d;
            idx_q       <= idx_d;
            tmr_q       <= tmr_d;
            retry_q     <= retry_d;
            err_code_q  <= err_code_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
            data_out_q  <= data_out_d;
            full_q      <= full_d;
            busy_q      <= busy_d;
            sent_q      <= sent_d;
            tx_err_q    <= tx_err_d;
        end
    end

    assign CLK_PS2_OUT_EN  = clk_oe_q;
    assign DATA_PS2_OUT    = data_out_q;
    assign DATA_PS2_OUT_EN = data_oe_q;
    assign FIFO_FULL       = full_q;
    assign BUSY            = busy_q;
    assign BYTE_SENT       = sent_q;
    assign TX_ERROR        = tx_err_q;
    assign ERROR_CODE      = err_code_q;

endmodule
